// File: rtl/exc_pkg.sv
// Shared types and constants for the vectored exception unit: stack frame
// layout, readout selects and default vector table geometry.
package exc_pkg;

    localparam int EXC_N = 64;

    localparam logic [EXC_N-1:0] VBASE_DEF   = 64'hD800;
    localparam int               VSTRIDE_DEF = 128;

    localparam logic [1:0] EDATA_ELR  = 2'b00;
    localparam logic [1:0] EDATA_ESR  = 2'b01;
    localparam logic [1:0] EDATA_ERR  = 2'b10;
    localparam logic [1:0] EDATA_STAT = 2'b11;

    typedef struct packed {
        logic [EXC_N-1:0] elr;
        logic [7:0]       esr;
        logic [EXC_N-1:0] err;
    } exc_frame_t;

endpackage

// File: rtl/exc_unit_vec_if.sv
// Datapath-facing signal bundle of the exception unit. master = fetch/execute
// side, slave = exception unit.
interface exc_unit_vec_if #(
    parameter int N       = 64,
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [NUM_SRC-1:0] exc_req;
    logic [NUM_SRC-1:0] exc_mask;
    logic               eret;
    logic [N-1:0]       next_pc;
    logic [N-1:0]       fault_addr;
    logic [N-1:0]       branch_in;
    logic [1:0]         edata_sel;
    logic               eproc;
    logic [N-1:0]       evaddr;
    logic [N-1:0]       pc_branch;
    logic [N-1:0]       read_data;
    logic [NUM_SRC-1:0] exc_ack;
    logic [DW-1:0]      depth;
    logic               stack_full;
    logic               eret_err;

    modport master (
        output exc_req, exc_mask, eret, next_pc, fault_addr, branch_in, edata_sel,
        input  eproc, evaddr, pc_branch, read_data, exc_ack, depth, stack_full, eret_err
    );

    modport slave (
        input  exc_req, exc_mask, eret, next_pc, fault_addr, branch_in, edata_sel,
        output eproc, evaddr, pc_branch, read_data, exc_ack, depth, stack_full, eret_err
    );

endinterface

// File: rtl/exc_frame_stack.sv
// DEPTH-deep LIFO of return frames. Push and pop in the same cycle replace
// the top entry in place, so depth is unchanged.
module exc_frame_stack
    import exc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  exc_frame_t    frame_i,
    output exc_frame_t    top_o,
    output logic [DW-1:0] depth_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [DW-1:0] ONE = DW'(1);

    exc_frame_t    mem_q [DEPTH];
    logic [DW-1:0] depth_q, depth_d;
    logic [DW-1:0] wr_idx;
    logic          wr_en;
    logic          full, empty;

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = depth_q;
        depth_d = depth_q;
        if (push_i && pop_i && !empty) begin
            wr_en  = 1'b1;
            wr_idx = depth_q - ONE;
        end else if (push_i && !full) begin
            wr_en   = 1'b1;
            depth_d = depth_q + ONE;
        end else if (pop_i && !empty) begin
            depth_d = depth_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            depth_q <= depth_d;
            for (int i = 0; i < DEPTH; i++)
                if (wr_en && (DW'(i) == wr_idx)) mem_q[i] <= frame_i;
        end
    end

    // An empty stack reads as an all-zero frame.
    always_comb begin
        top_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (DW'(i + 1) == depth_q) top_o = mem_q[i];
    end

    assign depth_o = depth_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: rtl/exc_unit_vec.sv
// Vectored, nestable exception unit: priority-selects a request, steers fetch
// to its vector, and stacks return context so higher-priority sources preempt.
module exc_unit_vec
    import exc_pkg::*;
#(
    parameter  int             N       = EXC_N,
    parameter  int             NUM_SRC = 4,
    parameter  int             DEPTH   = 4,
    parameter  logic [N-1:0]   VBASE   = VBASE_DEF,
    parameter  int             VSTRIDE = VSTRIDE_DEF,
    localparam int             DW      = $clog2(DEPTH + 1)
) (
    input logic           clk,
    input logic           reset,
    exc_unit_vec_if.slave bus
);

    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] ack_d, ack_q;
    logic [7:0]         win;
    logic               take, pop;
    logic               eret_err_d, eret_err_q;
    exc_frame_t         top, push_frame;
    logic [DW-1:0]      depth;
    logic               full, empty;

    exc_frame_stack #(.DEPTH(DEPTH)) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (take),
        .pop_i   (pop),
        .frame_i (push_frame),
        .top_o   (top),
        .depth_o (depth),
        .full_o  (full),
        .empty_o (empty)
    );

    // Inside a handler only strictly higher-priority (lower index) sources preempt.
    always_comb begin
        elig = '0;
        win  = '0;
        for (int i = 0; i < NUM_SRC; i++)
            elig[i] = bus.exc_req[i] & ~bus.exc_mask[i] & (empty | (8'(i) < top.esr));
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (elig[i]) win = 8'(i);
    end

    assign take = (|elig) & ~full;
    assign pop  = bus.eret & ~empty;

    // A take coinciding with ERET returns to where the ERET would have gone.
    always_comb begin
        push_frame     = '0;
        push_frame.elr = pop ? top.elr : EXC_N'(bus.next_pc);
        push_frame.esr = win;
        push_frame.err = EXC_N'(bus.fault_addr);
    end

    always_comb begin
        ack_d = '0;
        for (int i = 0; i < NUM_SRC; i++)
            ack_d[i] = take & (win == 8'(i));
    end

    assign eret_err_d = eret_err_q | (bus.eret & empty);

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q      <= '0;
            eret_err_q <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            eret_err_q <= eret_err_d;
        end
    end

    always_comb begin
        case (bus.edata_sel)
            EDATA_ELR: bus.read_data = N'(top.elr);
            EDATA_ESR: bus.read_data = N'(top.esr);
            EDATA_ERR: bus.read_data = N'(top.err);
            default:   bus.read_data = N'({full, depth});
        endcase
    end

    assign bus.eproc      = take;
    assign bus.evaddr     = VBASE + N'(win) * N'(VSTRIDE);
    assign bus.pc_branch  = (pop && !take) ? N'(top.elr) : bus.branch_in;
    assign bus.exc_ack    = ack_q;
    assign bus.depth      = depth;
    assign bus.stack_full = full;
    assign bus.eret_err   = eret_err_q;

endmodule

// File: tb/tb_exc_unit_vec.sv
// Directed bench for exc_unit_vec: stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_exc_unit_vec;

    localparam int F_EPROC = 0;
    localparam int F_EVADDR = 1;
    localparam int F_PCB = 2;
    localparam int F_RD = 3;
    localparam int F_ACK = 4;
    localparam int F_DEPTH = 5;
    localparam int F_FULL = 6;
    localparam int F_ERR = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exc_unit_vec_if #(.N(64), .NUM_SRC(4), .DEPTH(4)) bus ();

    exc_unit_vec #(
        .N(64), .NUM_SRC(4), .DEPTH(4), .VBASE(64'hD800), .VSTRIDE(128)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        string       name;
        int          fld;
        logic [63:0] exp;
    } chk_t;

    chk_t sbq[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] act(int f);
        case (f)
            F_EPROC:  return 64'(bus.eproc);
            F_EVADDR: return bus.evaddr;
            F_PCB:    return bus.pc_branch;
            F_RD:     return bus.read_data;
            F_ACK:    return 64'(bus.exc_ack);
            F_DEPTH:  return 64'(bus.depth);
            F_FULL:   return 64'(bus.stack_full);
            default:  return 64'(bus.eret_err);
        endcase
    endfunction

    task automatic expect_at(int dly, string nm, int f, logic [63:0] v);
        sbq.push_back('{cyc + dly, nm, f, v});
    endtask

    always @(negedge clk) begin
        int k;
        logic [63:0] a;
        k = 0;
        while (k < sbq.size()) begin
            if (sbq[k].due == cyc) begin
                a = act(sbq[k].fld);
                n_vec++;
                if (a !== sbq[k].exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                             sbq[k].name, a, sbq[k].exp, cyc);
                end
                sbq.delete(k);
            end else begin
                k++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        bus.exc_req    = '0;
        bus.exc_mask   = '0;
        bus.eret       = 1'b0;
        bus.next_pc    = '0;
        bus.fault_addr = '0;
        bus.branch_in  = 64'h1000;
        bus.edata_sel  = 2'b00;
        repeat (2) step();

        // reset state
        step(); reset = 1'b0; bus.edata_sel = 2'b11;
        expect_at(0, "rst_depth", F_DEPTH, 0);
        expect_at(0, "rst_ack", F_ACK, 0);
        expect_at(0, "rst_eproc", F_EPROC, 0);
        expect_at(0, "rst_pcb", F_PCB, 64'h1000);
        expect_at(0, "rst_err", F_ERR, 0);
        expect_at(0, "rst_stat", F_RD, 0);

        // single exception from source 2
        step(); bus.edata_sel = 2'b00; bus.exc_req = 4'b0100;
        bus.next_pc = 64'h40; bus.fault_addr = 64'h111;
        expect_at(0, "t1_eproc", F_EPROC, 1);
        expect_at(0, "t1_evaddr", F_EVADDR, 64'hD900);
        expect_at(1, "t1_ack", F_ACK, 4'b0100);
        expect_at(1, "t1_depth", F_DEPTH, 1);
        step(); bus.exc_req = '0;
        expect_at(0, "t1_elr", F_RD, 64'h40);
        expect_at(0, "t1_noproc", F_EPROC, 0);
        expect_at(1, "t1_ack_end", F_ACK, 0);
        step(); bus.edata_sel = 2'b01;
        expect_at(0, "t1_esr", F_RD, 2);
        step(); bus.edata_sel = 2'b10;
        expect_at(0, "t1_errreg", F_RD, 64'h111);

        // lower priority held off, higher priority nests
        step(); bus.edata_sel = 2'b00; bus.exc_req = 4'b1000;
        expect_at(0, "t2_lowprio", F_EPROC, 0);
        step(); bus.exc_req = 4'b0001; bus.next_pc = 64'hD908;
        expect_at(0, "t2_eproc", F_EPROC, 1);
        expect_at(0, "t2_evaddr", F_EVADDR, 64'hD800);
        expect_at(1, "t2_depth", F_DEPTH, 2);
        expect_at(1, "t2_ack", F_ACK, 4'b0001);
        step(); bus.exc_req = '0; bus.eret = 1'b1;
        expect_at(0, "t2_eret1_pcb", F_PCB, 64'hD908);
        expect_at(1, "t2_eret1_depth", F_DEPTH, 1);
        step();
        expect_at(0, "t2_eret2_pcb", F_PCB, 64'h40);
        expect_at(1, "t2_eret2_depth", F_DEPTH, 0);
        step(); bus.eret = 1'b0;
        expect_at(0, "t2_pcb_idle", F_PCB, 64'h1000);

        // fill the stack 3 -> 2 -> 1 -> 0
        step(); bus.exc_req = 4'b1000; bus.next_pc = 64'h200;
        expect_at(0, "t3_take3", F_EPROC, 1);
        expect_at(0, "t3_vec3", F_EVADDR, 64'hD980);
        step(); bus.exc_req = 4'b1100; bus.next_pc = 64'h204;
        expect_at(0, "t3_take2", F_EPROC, 1);
        expect_at(0, "t3_vec2", F_EVADDR, 64'hD900);
        step(); bus.exc_req = 4'b1110; bus.next_pc = 64'h208;
        expect_at(0, "t3_vec1", F_EVADDR, 64'hD880);
        step(); bus.exc_req = 4'b1111; bus.next_pc = 64'h20C;
        expect_at(0, "t3_vec0", F_EVADDR, 64'hD800);
        expect_at(1, "t3_depth4", F_DEPTH, 4);
        expect_at(1, "t3_full", F_FULL, 1);
        step(); bus.edata_sel = 2'b11;
        expect_at(0, "t3_full_noproc", F_EPROC, 0);
        expect_at(0, "t3_stat", F_RD, 64'hC);
        step(); bus.eret = 1'b1; bus.edata_sel = 2'b00;
        expect_at(0, "t3_eret_noproc", F_EPROC, 0);
        expect_at(0, "t3_eret_pcb", F_PCB, 64'h20C);
        expect_at(1, "t3_depth3", F_DEPTH, 3);
        step(); bus.eret = 1'b0; bus.next_pc = 64'h300;
        expect_at(0, "t3_held_take", F_EPROC, 1);
        expect_at(0, "t3_held_vec", F_EVADDR, 64'hD800);
        expect_at(1, "t3_redepth4", F_DEPTH, 4);
        step(); bus.exc_req = '0; bus.eret = 1'b1;
        expect_at(0, "t3_unw1", F_PCB, 64'h300);
        step();
        expect_at(0, "t3_unw2", F_PCB, 64'h208);
        step();
        expect_at(0, "t3_unw3", F_PCB, 64'h204);
        step();
        expect_at(0, "t3_unw4", F_PCB, 64'h200);
        expect_at(1, "t3_unw_depth", F_DEPTH, 0);

        // ERET with empty stack
        step(); bus.branch_in = 64'h100;
        expect_at(0, "t4_pcb", F_PCB, 64'h100);
        expect_at(1, "t4_depth", F_DEPTH, 0);
        expect_at(1, "t4_err", F_ERR, 1);
        step(); bus.eret = 1'b0; bus.branch_in = 64'h1000;
        repeat (3) step();
        expect_at(0, "t4_err_sticky", F_ERR, 1);

        // simultaneous ERET and take replaces the top
        step(); bus.exc_req = 4'b0010; bus.next_pc = 64'h80;
        expect_at(1, "t5_depth1", F_DEPTH, 1);
        step(); bus.exc_req = '0;
        step(); bus.eret = 1'b1; bus.exc_req = 4'b0001; bus.fault_addr = 64'h555;
        expect_at(0, "t5_eproc", F_EPROC, 1);
        expect_at(0, "t5_pcb", F_PCB, 64'h1000);
        expect_at(1, "t5_depth", F_DEPTH, 1);
        expect_at(1, "t5_ack", F_ACK, 4'b0001);
        step(); bus.eret = 1'b0; bus.exc_req = '0; bus.edata_sel = 2'b00;
        expect_at(0, "t5_elr", F_RD, 64'h80);
        step(); bus.edata_sel = 2'b01;
        expect_at(0, "t5_esr", F_RD, 0);
        step(); bus.edata_sel = 2'b10;
        expect_at(0, "t5_errreg", F_RD, 64'h555);

        // masking, then reset mid-handler with a request held across it
        step(); bus.edata_sel = 2'b00; bus.eret = 1'b1;
        expect_at(0, "t6_pop_pcb", F_PCB, 64'h80);
        expect_at(1, "t6_pop_depth", F_DEPTH, 0);
        step(); bus.eret = 1'b0; bus.exc_req = 4'b0001; bus.exc_mask = 4'b0001;
        expect_at(0, "t6_masked", F_EPROC, 0);
        expect_at(1, "t6_masked_depth", F_DEPTH, 0);
        step(); bus.exc_mask = '0; bus.exc_req = 4'b0100;
        expect_at(0, "t6_take2", F_EPROC, 1);
        step(); bus.exc_req = 4'b0110;
        step(); bus.exc_req = 4'b0111;
        expect_at(1, "t6_depth3", F_DEPTH, 3);
        step(); reset = 1'b1; bus.exc_req = 4'b0010;
        expect_at(0, "t6_pre_ack", F_ACK, 4'b0001);
        expect_at(1, "t6_rst_depth", F_DEPTH, 0);
        expect_at(1, "t6_rst_ack", F_ACK, 0);
        expect_at(1, "t6_rst_err", F_ERR, 0);
        step(); reset = 1'b0;
        expect_at(0, "t6_held_eproc", F_EPROC, 1);
        expect_at(0, "t6_held_vec", F_EVADDR, 64'hD880);
        expect_at(1, "t6_held_depth", F_DEPTH, 1);
        expect_at(1, "t6_held_ack", F_ACK, 4'b0010);
        step(); bus.exc_req = '0;
        repeat (3) step();

        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
